// File: rtl/gtx_tx_arbiter_if.sv
// Bundle of the requester-side AXI-stream inputs and the merged core2gtp output stream.
interface gtx_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Every channel transfers a word on a rising edge where valid && ready are both high;
  // valid never waits on ready, and valid/data/last hold steady until that transfer.
  logic [NUM_REQ*32-1:0] req_tdata;
  logic [NUM_REQ-1:0]    req_tvalid;
  logic [NUM_REQ-1:0]    req_tlast;
  logic [NUM_REQ-1:0]    req_tready;
  logic [31:0]           core2gtp_tdata;
  logic                  core2gtp_tvalid;
  logic                  core2gtp_tlast;
  logic                  core2gtp_tready;

  modport master (
    input  req_tdata, req_tvalid, req_tlast, core2gtp_tready,
    output req_tready, core2gtp_tdata, core2gtp_tvalid, core2gtp_tlast
  );

  modport slave (
    output req_tdata, req_tvalid, req_tlast, core2gtp_tready,
    input  req_tready, core2gtp_tdata, core2gtp_tvalid, core2gtp_tlast
  );
endinterface

// File: rtl/gtx_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_REQ AXI-stream requesters into the
// GTX TX stream, prefixing each packet with a {magic, seq, source} header word.
module gtx_tx_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          ID_W      = 2,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
  input  logic                 core_clk,
  input  logic                 reset,
  input  logic                 channel_up,
  gtx_tx_arbiter_if.master     bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [7:0]      seq;
  logic            cu_meta;
  logic            cu_sync;

  logic [31:0]     req_data_a [NUM_REQ];
  logic            pick_found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            data_hs;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_a[i] = bus.req_tdata[32*i +: 32];
  end

  // Rotating search starting just after the previous grantee.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && bus.req_tvalid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  assign data_hs   = bus.req_tvalid[grant_id] && bus.core2gtp_tready;
  assign fsm_state = state;
  assign busy      = !reset && (state != IDLE);

  // DATA is a combinational pass-through so payload streams with no added latency.
  always_comb begin
    bus.core2gtp_tdata  = '0;
    bus.core2gtp_tvalid = 1'b0;
    bus.core2gtp_tlast  = 1'b0;
    bus.req_tready      = '0;
    if (!reset) begin
      case (state)
        HDR: begin
          bus.core2gtp_tvalid = 1'b1;
          bus.core2gtp_tdata  = {HDR_MAGIC, seq, 8'(grant_id)};
        end
        DATA: begin
          bus.core2gtp_tdata       = req_data_a[grant_id];
          bus.core2gtp_tvalid      = bus.req_tvalid[grant_id];
          bus.core2gtp_tlast       = bus.req_tlast[grant_id];
          bus.req_tready[grant_id] = bus.core2gtp_tready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      seq        <= 8'h00;
      pkt_count  <= 16'h0000;
      grant_id   <= '0;
      cu_meta    <= 1'b0;
      cu_sync    <= 1'b0;
    end else begin
      cu_meta <= channel_up;
      cu_sync <= cu_meta;
      case (state)
        IDLE: begin
          // Link status only gates new grants; an in-flight packet always completes.
          if (cu_sync && pick_found) begin
            grant_id <= pick;
            state    <= HDR;
          end
        end
        HDR: begin
          if (bus.core2gtp_tready) begin
            seq   <= seq + 8'd1;
            state <= DATA;
          end
        end
        DATA: begin
          if (data_hs && bus.req_tlast[grant_id]) begin
            last_grant <= grant_id;
            pkt_count  <= pkt_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
